fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch front end and request side of the i-cache read interface. It drives en/addr into the synchronous i-cache and captures the 1-cycle-latency rdata/rvalid response. Each fetched instruction is buffered as a {pc, inst} pair in a small flush-able queue that feeds decode through a valid/ready handshake. It also handles pipeline redirects from the back end.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (low 2 bits must be 0)
FQ_DEPTH, 4, fetch-queue entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ic_en  out  1  i-cache read request
ic_addr  out  32  i-cache byte address (word aligned)
ic_rdata  in  32  i-cache read data, valid with ic_rvalid
ic_rvalid  in  1  i-cache response valid, exactly 1 cycle after ic_en
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC
out_valid  out  1  queue head valid toward decode
out_pc  out  32  PC of head instruction
out_inst  out  32  head instruction word
out_ready  in  1  decode accepts head

Behaviour:
- Reset (rst_n=0 at posedge) clears all state:
  - pc=RESET_PC, inflight=0, queue count=0.
  - Outputs: ic_en=0, ic_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=32'h0000_0013.
- Issue condition: issue = !redirect_valid && (count + inflight) < FQ_DEPTH.
  - The credit check is conservative and ignores a same-cycle pop.
  - ic_en=issue, ic_addr=pc; both are combinational from registered state.
- On issue:
  - pc <= pc+4, with mod-2^32 wrap: 32'hFFFF_FFFC -> 0.
  - inflight <= 1, inflight_pc <= pc.
  - If no issue, inflight <= 0.
- Response, in the cycle after an issue:
  - If inflight && ic_rvalid: push {inflight_pc, ic_rdata}.
  - If ic_rvalid && !inflight: stale response, ignore it.
  - If inflight && !ic_rvalid: protocol miss. Replay by setting pc <= inflight_pc. This overrides the pc+4 from a same-cycle issue, and that issue's inflight is cancelled.
- Queue output:
  - out_valid = (count != 0); out_pc/out_inst are the head entry.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged.
  - No bypass: a push into an empty queue is visible the next cycle.
  - Latency from ic_en to out_valid is 2 cycles.
  - Sustained throughput is 1 instr/cycle while out_ready=1.
- Full: the credit rule guarantees no push when full. A push when full is an assertion failure.
- Redirect (redirect_valid=1 at posedge):
  - pc <= {redirect_pc[31:2], 2'b00}, count <= 0, inflight <= 0.
  - The response arriving next cycle is dropped.
  - ic_en=0 in the redirect cycle; fetch from the new pc starts the following cycle.
  - Redirect beats a same-cycle pop or push; both are discarded.
  - Back-to-back redirects: the last one wins.
- Reset asserted mid-stream: discard everything, including any in-flight response.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds output ports perf_fetched[31:0] and perf_dropped[31:0].
  - perf_fetched counts pushes.
  - perf_dropped counts responses discarded by redirect or stale-rvalid, plus queue entries flushed by redirect.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - NOP_INST = 32'h0000_0013.
  - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t.
  - fetch_count_t, sized $clog2(FQ_DEPTH)+1.
- Sub-module fetch_queue: synchronous circular FIFO of fetch_entry_t.
  - Signals: push, pop, flush, count, head; flush has priority.
  - The parent holds the PC, inflight tracking and credit logic.

Test Plan:
- Reset release, out_ready=1, cache holds words 0x...00,0x...04,...:
  - ic_en=1 with ic_addr=0x0 in the first cycle after reset.
  - ic_addr 0x4, 0x8 follow each cycle.
  - out_valid rises 2 cycles after the first issue with out_pc=0x0, then one entry per cycle.
- out_ready=0 from reset, FQ_DEPTH=4:
  - Exactly 4 issues (addr 0x0-0xC), then ic_en=0; count=4 and stays.
  - Raise out_ready: one pop per cycle, issue resumes at 0x10 with no lost or duplicated PCs.
- Redirect to 0x103 while queue holds 3 entries and a response is in flight:
  - Next cycle out_valid=0 and the in-flight rdata is dropped.
  - ic_en=0 in the redirect cycle, then ic_addr=0x100.
  - The next out_pc is 0x100.
- Inject ic_rvalid=1 with no outstanding request -> queue unchanged.
- Suppress ic_rvalid for the response to 0x20 -> fetch replays 0x20; the output stream stays 0x1C, 0x20, 0x24.
- RESET_PC=0xFFFF_FFF8 -> issues 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. With FETCH_PERF_EN, a redirect with 2 queued entries plus 1 in flight adds 3 to perf_dropped.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Default queue depth; fetch_count_t is sized for it.
  localparam int FQ_DEPTH_DFLT = 4;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown on the head when the queue is empty.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef logic [$clog2(FQ_DEPTH_DFLT):0] fetch_count_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, inst} fetch entries; flush has priority over push/pop.
// Latency: a push becomes visible on head the cycle after it is written (no bypass).
// Backpressure: pop is ignored when empty; the parent's credit logic guarantees no push when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = DEPTH[CW-1:0];

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; a flushed push is simply not written.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr] <= wr_entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '{pc: 32'h0, inst: NOP_INST};

  // A push into a full queue means the credit accounting upstream is broken.
  always @(posedge clk) begin
    if (rst_n && push && !flush) assert (count != FULL_C);
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: issues i-cache reads, tracks the 1-cycle response, queues {pc, inst} to decode.
// Latency: 2 cycles from ic_en to out_valid; 1 instr/cycle sustained while out_ready=1.
// Backpressure: credit on queue occupancy + in-flight read; FETCH_PERF_EN adds fetch/drop counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = FQ_DEPTH_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_en,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_rvalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = FQ_DEPTH[CW:0];

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          miss;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  // Credits are conservative: a pop in this same cycle is not counted as freeing a slot.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue       = rst_n && !redirect_valid && (credit_used < DEPTH_C);
  assign ic_en       = issue;
  assign ic_addr     = pc;

  assign miss     = inflight && !ic_rvalid;
  assign push     = inflight && ic_rvalid && !redirect_valid;
  assign pop      = out_valid && out_ready;
  assign wr_entry = '{pc: inflight_pc, inst: ic_rdata};

  // PC sequencing: redirect beats replay, replay beats the normal +4 advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
    end else if (miss) begin
      // The cache dropped our read: refetch it and cancel any read issued this cycle.
      pc       <= inflight_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

`ifdef FETCH_PERF_EN
  logic        drop_rsp;
  logic [CW:0] drop_inc;
  logic [32:0] drop_sum;

  // A response is wasted if a redirect kills it or nothing was waiting for it.
  assign drop_rsp = ic_rvalid && (redirect_valid || !inflight);
  assign drop_inc = (redirect_valid ? {1'b0, count} : '0) + {{CW{1'b0}}, drop_rsp};
  assign drop_sum = {1'b0, perf_dropped} + {{(32 - CW){1'b0}}, drop_inc};

  // Saturating fetch and drop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      perf_dropped <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized stream check.
// The i-cache is modelled as a word function of the address, answering one cycle after ic_en.
// A second instance with RESET_PC near the top of the address space checks PC wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ic_en, w_ic_en;
  logic [31:0] ic_addr, w_ic_addr;
  logic [31:0] ic_rdata, w_ic_rdata;
  logic        ic_rvalid, w_ic_rvalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, w_out_valid;
  logic [31:0] out_pc, w_out_pc;
  logic [31:0] out_inst, w_out_inst;
  logic        out_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, w_perf_fetched, w_perf_dropped;
`endif

  logic        prev_en, w_prev_en;
  logic [31:0] prev_addr, w_prev_addr;
  int          checks;
  int          errors;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .ic_en(ic_en), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_rvalid(ic_rvalid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .FQ_DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ic_en(w_ic_en), .ic_addr(w_ic_addr), .ic_rdata(w_ic_rdata),
    .ic_rvalid(w_ic_rvalid), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_pc(w_out_pc), .out_inst(w_out_inst), .out_ready(1'b1)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_dropped(w_perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache contents: an address-derived word, so every PC maps to a distinct instruction.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs at the falling edge, let combinational outputs settle,
  // and remember this cycle's request so the cache model answers it next cycle.
  task automatic cycle(input logic rst, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic supp, input logic inj);
    @(negedge clk);
    rst_n          = rst;
    ic_rvalid      = (prev_en && !supp) || inj;
    ic_rdata       = prev_en ? memw(prev_addr) : 32'hDEAD_BEEF;
    w_ic_rvalid    = w_prev_en;
    w_ic_rdata     = memw(w_prev_addr);
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    prev_en     = ic_en;
    prev_addr   = ic_addr;
    w_prev_en   = w_ic_en;
    w_prev_addr = w_ic_addr;
  endtask

  task automatic reset_dut(input logic rdy);
    for (int k = 0; k < 3; k++) cycle(1'b0, rdy, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_dut(1'b1);
    checks++; if (ic_en !== 1'b0) begin errors++; $display("FAIL reset_ic_en: got %b want 0", ic_en); end
    checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL reset_ic_addr: got %h want 0", ic_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    checks++; if (out_inst !== NOP_INST) begin errors++; $display("FAIL reset_out_inst: got %h want %h", out_inst, NOP_INST); end
    checks++; if (w_ic_addr !== WRAP_PC) begin errors++; $display("FAIL reset_wrap_addr: got %h want %h", w_ic_addr, WRAP_PC); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0) begin
      errors++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_dropped); end
`endif
  endtask

  // Free-flowing decode: one issue and one delivery per cycle, first delivery 2 cycles after first issue.
  task automatic test_basic();
    logic [31:0] e;
    reset_dut(1'b1);
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      e = 32'(4 * k);
      checks++; if (ic_en !== 1'b1 || ic_addr !== e) begin
        errors++; $display("FAIL basic_issue[%0d]: got en=%b addr=%h want en=1 addr=%h", k, ic_en, ic_addr, e); end
      if (k < 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency[%0d]: out_valid=%b want 0", k, out_valid); end
      end else begin
        e = 32'(4 * (k - 2));
        checks++; if (out_valid !== 1'b1 || out_pc !== e || out_inst !== memw(e)) begin
          errors++; $display("FAIL basic_out[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                             k, out_valid, out_pc, out_inst, e, memw(e)); end
      end
    end
  endtask

  // Decode stalled: fetch stops after FQ_DEPTH issues, then drains and refills without gaps.
  task automatic test_backpressure();
    int          issues;
    logic [31:0] exp_pc;
    logic        seen;
    issues = 0;
    reset_dut(1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (ic_en === 1'b1) begin
        checks++; if (ic_addr !== 32'(4 * issues)) begin
          errors++; $display("FAIL bp_issue_addr: got %h want %h", ic_addr, 32'(4 * issues)); end
        issues++;
      end
    end
    checks++; if (issues != 4) begin errors++; $display("FAIL bp_issue_count: got %0d want 4", issues); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
    exp_pc = 32'h0;
    seen   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      if (ic_en === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++; if (ic_addr !== 32'h10) begin errors++; $display("FAIL bp_resume_addr: got %h want 00000010", ic_addr); end
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_pc !== exp_pc || out_inst !== memw(exp_pc)) begin
          errors++; $display("FAIL bp_drain: got pc=%h inst=%h want pc=%h", out_pc, out_inst, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_pc !== 32'h40) begin errors++; $display("FAIL bp_throughput: delivered up to %h want 00000040", exp_pc); end
  endtask

  // Redirect with nq entries queued and one response arriving in the redirect cycle.
  task automatic test_redirect(input int nq, input logic [31:0] tgt);
    logic [31:0] al;
`ifdef FETCH_PERF_EN
    logic [31:0] base;
`endif
    al = tgt & 32'hFFFF_FFFC;
    reset_dut(1'b0);
    for (int k = 0; k <= nq; k++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    base = perf_dropped;
`endif
    cycle(1'b1, 1'b0, 1'b1, tgt, 1'b0, 1'b0);
    checks++; if (ic_en !== 1'b0) begin errors++; $display("FAIL redir_en_in_cycle: got %b want 0", ic_en); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: out_valid=%b want 0", out_valid); end
    checks++; if (ic_en !== 1'b1 || ic_addr !== al) begin
      errors++; $display("FAIL redir_new_addr: got en=%b addr=%h want en=1 addr=%h", ic_en, ic_addr, al); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_drop_inflight: out_valid=%b want 0", out_valid); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== al || out_inst !== memw(al)) begin
      errors++; $display("FAIL redir_first_out: got v=%b pc=%h inst=%h want pc=%h", out_valid, out_pc, out_inst, al); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_dropped - base !== 32'(nq + 1)) begin
      errors++; $display("FAIL redir_perf_dropped: got +%0d want +%0d", perf_dropped - base, nq + 1); end
`endif
  endtask

  // A response with nothing outstanding must not enter the (freshly flushed) queue.
  task automatic test_stale();
`ifdef FETCH_PERF_EN
    logic [31:0] base;
`endif
    reset_dut(1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    base = perf_dropped;
`endif
    cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_pre: out_valid=%b want 0", out_valid); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_ignored: out_valid=%b want 0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(4 * k)) begin
        errors++; $display("FAIL stale_stream[%0d]: got v=%b pc=%h want pc=%h", k, out_valid, out_pc, 32'h200 + 32'(4 * k)); end
    end
`ifdef FETCH_PERF_EN
    checks++; if (perf_dropped - base !== 32'd3) begin
      errors++; $display("FAIL stale_perf_dropped: got +%0d want +3", perf_dropped - base); end
`endif
  endtask

  // The cache withholds the response for 0x20: fetch must refetch it and keep order.
  task automatic test_replay();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    reset_dut(1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, k == 9, 1'b0);
      if (k == 10) begin
        checks++; if (ic_en !== 1'b1 || ic_addr !== 32'h20) begin
          errors++; $display("FAIL replay_addr: got en=%b addr=%h want en=1 addr=00000020", ic_en, ic_addr); end
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_pc !== exp_pc || out_inst !== memw(exp_pc)) begin
          errors++; $display("FAIL replay_stream: got pc=%h inst=%h want pc=%h", out_pc, out_inst, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_pc < 32'h28) begin errors++; $display("FAIL replay_progress: delivered up to %h want >= 00000028", exp_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    reset_dut(1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      e = WRAP_PC + 32'(4 * k);
      if (k < 3) begin
        checks++; if (w_ic_en !== 1'b1 || w_ic_addr !== e) begin
          errors++; $display("FAIL wrap_issue[%0d]: got en=%b addr=%h want %h", k, w_ic_en, w_ic_addr, e); end
      end
      if (k >= 2) begin
        e = WRAP_PC + 32'(4 * (k - 2));
        checks++; if (w_out_valid !== 1'b1 || w_out_pc !== e || w_out_inst !== memw(e)) begin
          errors++; $display("FAIL wrap_out[%0d]: got v=%b pc=%h want pc=%h", k, w_out_valid, w_out_pc, e); end
      end
    end
  endtask

  // Reset in the middle of traffic discards queue contents and the outstanding read.
  task automatic test_midreset();
    reset_dut(1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || ic_en !== 1'b1 || ic_addr !== 32'h0) begin
      errors++; $display("FAIL midreset_restart: got v=%b en=%b addr=%h want v=0 en=1 addr=0", out_valid, ic_en, ic_addr); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_drop: out_valid=%b want 0", out_valid); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL midreset_first: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
  endtask

  // Random decode stalls, redirects, withheld and spurious responses. The model is just the
  // program-order expectation: every accepted instruction is the next sequential PC since the
  // last redirect (or reset), carrying the cache word for that PC.
  task automatic test_random();
    logic [31:0] exp_pc, rpc;
    logic        rdy, redir, supp, inj;
    int          drained;
    exp_pc  = 32'h0;
    drained = 0;
    reset_dut(1'b1);
    for (int i = 0; i < 2030; i++) begin
      rdy   = (i >= 2000) || ($urandom_range(0, 3) != 0);
      redir = (i < 2000) && ($urandom_range(0, 49) == 0);
      rpc   = $urandom;
      supp  = (i < 2000) && ($urandom_range(0, 15) == 0);
      inj   = (i < 2000) && ($urandom_range(0, 15) == 0);
      cycle(1'b1, rdy, redir, rpc, supp, inj);
      if (out_valid === 1'b1 && rdy && !redir) begin
        checks++; if (out_pc !== exp_pc || out_inst !== memw(exp_pc)) begin
          errors++; $display("FAIL random_stream[%0d]: got pc=%h inst=%h want pc=%h inst=%h",
                             i, out_pc, out_inst, exp_pc, memw(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        if (i >= 2000) drained++;
      end
      if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
    end
    checks++; if (drained < 20) begin errors++; $display("FAIL random_liveness: %0d deliveries in drain want >= 20", drained); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    ic_rvalid      = 1'b0;
    ic_rdata       = 32'h0;
    w_ic_rvalid    = 1'b0;
    w_ic_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    prev_en        = 1'b0;
    prev_addr      = 32'h0;
    w_prev_en      = 1'b0;
    w_prev_addr    = 32'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect(3, 32'h0000_0103);
    test_redirect(2, 32'h0000_2002);
    test_stale();
    test_replay();
    test_wrap();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
